// File: rtl/countdown_timer.sv
// Programmable down-counting timer with divide-by-1/4 tick rate, one-shot or
// auto-reload operation, and a sticky registered interrupt.
module countdown_timer #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Slt,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             IrqAck,
  output logic [WIDTH-1:0] Count,
  output logic             Irq,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic             mode_q, mode_d;
  logic [1:0]       pre_q, pre_d;
  logic             irq_q, irq_d;
  logic             tick;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    mode_d   = mode_q;
    pre_d    = pre_q;
    irq_d    = irq_q;
    tick     = 1'b0;

    if (Load) begin
      preset_d = LoadVal;
      count_d  = LoadVal;
      mode_d   = Mode;
      pre_d    = 2'd0;
      irq_d    = 1'b0;
      state_d  = (LoadVal != '0) ? COUNT : IDLE;
    end else begin
      if (state_q == COUNT && En) begin
        if (Slt) pre_d = pre_q + 2'd1;
        tick = !Slt || (pre_q == 2'd3);
      end

      // Acknowledge is applied first so a same-edge expiry below overrides it.
      if (irq_q && IrqAck) begin
        irq_d = 1'b0;
        if (state_q == DONE) state_d = IDLE;
      end

      if (tick) begin
        if (count_q == WIDTH'(1)) begin
          irq_d = 1'b1;
          if (mode_q) begin
            count_d = preset_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      preset_q <= '0;
      mode_q   <= 1'b0;
      pre_q    <= 2'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      irq_q    <= irq_d;
    end
  end

  assign Count = count_q;
  assign Irq   = irq_q;
  assign Busy  = (state_q == COUNT);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer: one task per scenario,
// each with hand-computed expected values.
module tb_countdown_timer;

  localparam int WIDTH = 64;

  logic             Clk = 1'b0;
  logic             Reset, En, Slt, Mode, Load, IrqAck;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] Count;
  logic             Irq, Busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .En      (En),
    .Slt     (Slt),
    .Mode    (Mode),
    .Load    (Load),
    .LoadVal (LoadVal),
    .IrqAck  (IrqAck),
    .Count   (Count),
    .Irq     (Irq),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge, then settle; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val, input logic md, input logic slt);
    LoadVal = val;
    Mode    = md;
    Slt     = slt;
    Load    = 1'b1;
    step();
    Load    = 1'b0;
  endtask

  task automatic ack();
    IrqAck = 1'b1;
    step();
    IrqAck = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; En = 1'b1; Slt = 1'b0; Mode = 1'b0; Load = 1'b0;
    LoadVal = '0; IrqAck = 1'b0;
    step();
    step();
    Reset = 1'b0;
    total_cnt++;
    if (Count !== 64'd0 || Irq !== 1'b0 || Busy !== 1'b0)
      $display("FAIL reset: Count=%0h Irq=%b Busy=%b, want 0/0/0", Count, Irq, Busy);
    else pass_cnt++;
  endtask

  task automatic test_oneshot();
    En = 1'b1;
    load(64'd5, 1'b0, 1'b0);
    total_cnt++;
    if (Count !== 64'd5 || Busy !== 1'b1)
      $display("FAIL oneshot_load: Count=%0d Busy=%b, want 5/1", Count, Busy);
    else pass_cnt++;
    for (int i = 4; i >= 0; i--) begin
      step();
      total_cnt++;
      if (Count !== 64'(i))
        $display("FAIL oneshot_count: Count=%0d, want %0d", Count, i);
      else pass_cnt++;
    end
    total_cnt++;
    if (Irq !== 1'b1 || Busy !== 1'b0)
      $display("FAIL oneshot_expiry: Irq=%b Busy=%b, want 1/0", Irq, Busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Irq !== 1'b1 || Count !== 64'd0)
      $display("FAIL oneshot_sticky: Irq=%b Count=%0d, want 1/0", Irq, Count);
    else pass_cnt++;
    ack();
    step();
    step();
    total_cnt++;
    if (Irq !== 1'b0 || Count !== 64'd0 || Busy !== 1'b0)
      $display("FAIL oneshot_ack: Irq=%b Count=%0d Busy=%b, want 0/0/0", Irq, Count, Busy);
    else pass_cnt++;
  endtask

  task automatic test_prescale();
    logic [WIDTH-1:0] exp_cnt;
    int               en_cycles;
    En = 1'b1;
    load(64'd3, 1'b0, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_cnt = 64'(3 - e / 4);
      total_cnt++;
      if (Count !== exp_cnt || Irq !== (e == 12))
        $display("FAIL div4_edge%0d: Count=%0d Irq=%b, want %0d/%b", e, Count, Irq, exp_cnt, e == 12);
      else pass_cnt++;
    end
    ack();

    load(64'd3, 1'b0, 1'b1);
    en_cycles = 0;
    for (int e = 1; e <= 14; e++) begin
      En = !(e == 5 || e == 6);
      step();
      if (En) en_cycles++;
      exp_cnt = 64'(3 - en_cycles / 4);
      total_cnt++;
      if (Count !== exp_cnt || Irq !== (e == 14))
        $display("FAIL div4_stall_edge%0d: Count=%0d Irq=%b, want %0d/%b", e, Count, Irq, exp_cnt, e == 14);
      else pass_cnt++;
    end
    En = 1'b1;
    ack();
  endtask

  task automatic test_reload();
    logic [WIDTH-1:0] exp_seq [1:6] = '{64'd1, 64'd2, 64'd1, 64'd2, 64'd1, 64'd2};
    logic             exp_irq [1:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    En = 1'b1;
    load(64'd2, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      IrqAck = (e == 4 || e == 5);
      step();
      total_cnt++;
      if (Count !== exp_seq[e] || Irq !== exp_irq[e] || Busy !== 1'b1)
        $display("FAIL reload_edge%0d: Count=%0d Irq=%b Busy=%b, want %0d/%b/1",
                 e, Count, Irq, Busy, exp_seq[e], exp_irq[e]);
      else pass_cnt++;
    end
    IrqAck = 1'b0;
  endtask

  task automatic test_load_zero();
    logic saw_irq;
    load(64'd0, 1'b0, 1'b0);
    total_cnt++;
    if (Busy !== 1'b0 || Count !== 64'd0 || Irq !== 1'b0)
      $display("FAIL load_zero: Busy=%b Count=%0d Irq=%b, want 0/0/0", Busy, Count, Irq);
    else pass_cnt++;
    saw_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (Irq !== 1'b0 || Busy !== 1'b0) saw_irq = 1'b1;
    end
    total_cnt++;
    if (saw_irq !== 1'b0)
      $display("FAIL load_zero_idle: irq_or_busy_seen=%b, want 0", saw_irq);
    else pass_cnt++;
  endtask

  task automatic test_reload_midrun();
    En = 1'b1;
    load(64'd2, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step();
    total_cnt++;
    if (Count !== 64'd2 || Irq !== 1'b1)
      $display("FAIL midrun_setup: Count=%0d Irq=%b, want 2/1", Count, Irq);
    else pass_cnt++;
    load(64'd4, 1'b0, 1'b1);
    total_cnt++;
    if (Count !== 64'd4 || Irq !== 1'b0 || Busy !== 1'b1)
      $display("FAIL midrun_load: Count=%0d Irq=%b Busy=%b, want 4/0/1", Count, Irq, Busy);
    else pass_cnt++;
    step(); step(); step();
    total_cnt++;
    if (Count !== 64'd4)
      $display("FAIL midrun_pre_restart: Count=%0d, want 4", Count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Count !== 64'd3)
      $display("FAIL midrun_first_tick: Count=%0d, want 3", Count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    En = 1'b1;
    load(64'd10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    total_cnt++;
    if (Count !== 64'd6)
      $display("FAIL resetmid_setup: Count=%0d, want 6", Count);
    else pass_cnt++;
    Reset = 1'b1; Load = 1'b1; LoadVal = 64'd7;
    step();
    Reset = 1'b0; Load = 1'b0;
    total_cnt++;
    if (Count !== 64'd0 || Irq !== 1'b0 || Busy !== 1'b0)
      $display("FAIL resetmid: Count=%0d Irq=%b Busy=%b, want 0/0/0", Count, Irq, Busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Count !== 64'd0 || Busy !== 1'b0)
      $display("FAIL resetmid_hold: Count=%0d Busy=%b, want 0/0", Count, Busy);
    else pass_cnt++;
  endtask

  task automatic test_max();
    En = 1'b1;
    load({WIDTH{1'b1}}, 1'b0, 1'b0);
    total_cnt++;
    if (Count !== 64'hFFFF_FFFF_FFFF_FFFF || Busy !== 1'b1)
      $display("FAIL max_load: Count=%0h Busy=%b, want ffffffffffffffff/1", Count, Busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (Count !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL max_dec: Count=%0h, want fffffffffffffffe", Count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_prescale();
    test_reload();
    test_load_zero();
    test_reload_midrun();
    test_reset_mid();
    test_max();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer, the counterpart of the team's free-running up-counter: software loads a preset, the block counts it down to zero and raises a sticky interrupt. `Slt` selects a divide-by-1 or divide-by-4 tick rate, using the same select semantics as the up-counter. Counting runs in one-shot or auto-reload mode. The block sits beside the up-counter in the timer/peripheral group and drives an interrupt line toward the CPU.

## Interface
- `WIDTH`, default 64: width of preset and count registers.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high; clears all state on the edge where it is sampled high.
- `En` input 1: count enable; when low, count and prescaler hold.
- `Slt` input 1: tick-rate select. 0 = tick on every enabled cycle. 1 = tick on every 4th enabled cycle.
- `Mode` input 1: 0 = one-shot, 1 = auto-reload. Sampled at Load.
- `Load` input 1: load strobe, one cycle.
- `LoadVal` input WIDTH: preset value, captured when `Load` is high.
- `IrqAck` input 1: interrupt acknowledge, one cycle.
- `Count` output WIDTH: current count register.
- `Irq` output 1: sticky interrupt, registered.
- `Busy` output 1: high while in state COUNT.

## Operation
- Internal registers:
  - Preset[WIDTH-1:0]
  - ModeR
  - 2-bit prescaler Pre
  - state ∈ {IDLE, COUNT, DONE}
- Priority on each edge: Reset > Load > tick/expiry > IrqAck.
- Reset: Count=0, Preset=0, Pre=0, ModeR=0, Irq=0, state=IDLE, so Busy=0.
- Load:
  - Preset=Count=LoadVal, ModeR=Mode, Pre=0, Irq=0.
  - state=COUNT if LoadVal≠0, otherwise IDLE.
  - Load is accepted in any state and restarts the timer.
- Tick, valid only in COUNT with En=1:
  - Slt=0: every such cycle is a tick.
  - Slt=1: Pre increments on each enabled cycle (wraps 3→0); a tick occurs when Pre==3.
  - Pre holds when En=0. A change of Slt mid-count does not clear Pre.
- On a tick with Count>1: Count=Count−1.
- Expiry (tick with Count==1):
  - ModeR=0: Count=0, Irq=1, state=DONE.
  - ModeR=1: Count=Preset, Irq=1, state stays COUNT.
- IrqAck:
  - Clears Irq. In DONE, also moves state to IDLE.
  - IrqAck on the same edge as an expiry: expiry wins and Irq stays 1.
  - IrqAck while Irq=0: no effect.
- IDLE and DONE: Count holds; En, Slt and tick have no effect.
- Arithmetic: unsigned WIDTH-bit. Count never underflows, because decrement only happens from values ≥1. A preset of 2^WIDTH−1 is legal.

## Timing
- Load sampled at edge k: Count=LoadVal and Busy=1 are visible after edge k.
- Slt=0, En=1 continuously from cycle k+1: Count reaches 0 and Irq=1 after edge k+N, where N=LoadVal.
- Slt=1, En=1 continuously: ticks at edges k+4, k+8, …; expiry after edge k+4N.
- Each En=0 cycle delays expiry by exactly one cycle, in both rates.
- Auto-reload period: N ticks. Count sequence N, N−1, …, 1, N, …; Count never shows 0. Irq rises at the end of each period.
- Irq is a registered output with no combinational path from inputs. It falls one edge after IrqAck, unless an expiry occurs on that same edge.
- Busy falls on the expiry edge (one-shot) or on the Reset edge.
- Reset mid-count: all outputs are 0 after the Reset edge. A Load issued in the same cycle as Reset is ignored.

## Test plan
- Reset, then Load LoadVal=5, Mode=0, Slt=0, En=1 → Count 5,4,3,2,1,0 on consecutive edges; Irq=1 and Busy=0 after the 5th edge; IrqAck → Irq=0, state IDLE, Count stays 0.
- Load 3, Slt=1, En=1 → Count decrements only at edges +4, +8, +12; Irq=1 after edge +12. Repeat with En=0 for 2 cycles mid-count → Irq after edge +14.
- Load 2, Mode=1, Slt=0 → Count 2,1,2,1,2…; Irq=1 after edge +2; IrqAck pulsed exactly on edge +4 (a second expiry) → Irq stays 1.
- Load 0 → Busy=0, Count=0, Irq never asserts over 20 cycles. Load 4 while Count=2 in a running timer → Count=4, Irq cleared, Pre restarts.
- Load 10 running, Reset at Count=6 → Count=0, Irq=0, Busy=0 next edge. Load 2^64−1 with one decrement → Count=0xFFFF_FFFF_FFFF_FFFE.
